// File: rtl/apb_mst_pkg.sv
// Shared types and constants for the APB master bridge.
// The FSM encoding, default bus widths and wait-counter width live here.
package apb_mst_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_mst_wdog.sv
// ACCESS-phase wait counter for the APB master bridge.
// It is only instantiated when APB_MST_PREADY_EN is defined.
module apb_mst_wdog
  import apb_mst_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic pclk,
  input  logic prst,
  input  logic clr,
  input  logic cnt_en,
  output logic expired
);

  // expired marks the TIMEOUT-th ACCESS cycle, because the count starts at zero
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_r;

  // wait counter: cleared before ACCESS, steps on each stalled ACCESS cycle
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_en) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == LIMIT);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: valid/ready command in, APB SETUP/ACCESS out, response back.
// Optional pready/pslverr support and ACCESS timeout are enabled with APB_MST_PREADY_EN.
module apb_master_bridge
  import apb_mst_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_prot,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic [2:0]        pprot,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
`ifdef APB_MST_PREADY_EN
  input  logic              pready,
  input  logic              pslverr,
`endif
  input  logic [DATA_W-1:0] prdata
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT must be within 1..65535");
  end

  apb_state_e state_r;
  apb_state_e next_s;
  logic       accept_s;
  logic       done_s;
  logic       err_s;

  assign accept_s = (state_r == ST_IDLE) && cmd_valid && cmd_ready;

`ifdef APB_MST_PREADY_EN
  logic expired_s;

  apb_mst_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .pclk    (pclk),
    .prst    (prst),
    .clr     (state_r == ST_SETUP),
    .cnt_en  ((state_r == ST_ACCESS) && !pready),
    .expired (expired_s)
  );

  // A timeout abort reports an error even though the slave never answered
  assign done_s = pready || expired_s;
  assign err_s  = pready ? pslverr : 1'b1;
`else
  assign done_s = 1'b1;
  assign err_s  = 1'b0;
`endif

  // next-state decode
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) next_s = ST_SETUP;
        else          next_s = ST_IDLE;
      end
      ST_SETUP: next_s = ST_ACCESS;
      ST_ACCESS: begin
        if (done_s) next_s = ST_RESP;
        else        next_s = ST_ACCESS;
      end
      ST_RESP: begin
        if (rsp_ready) next_s = ST_IDLE;
        else           next_s = ST_RESP;
      end
      default: next_s = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) state_r <= ST_IDLE;
    else      state_r <= next_s;
  end

  // handshake and APB strobes are registered decodes of the next state
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      psel      <= (next_s == ST_SETUP) || (next_s == ST_ACCESS);
      penable   <= (next_s == ST_ACCESS);
      cmd_ready <= (next_s == ST_IDLE);
      rsp_valid <= (next_s == ST_RESP);
    end
  end

  // command capture: APB address/data/control change only on acceptance
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      paddr  <= {ADDR_W{1'b0}};
      pwdata <= {DATA_W{1'b0}};
      pwrite <= 1'b0;
      pprot  <= 3'b000;
    end else if (accept_s) begin
      paddr  <= cmd_addr;
      pwdata <= cmd_wdata;
      pwrite <= cmd_write;
      pprot  <= cmd_prot;
    end
  end

  // response capture on the completing ACCESS cycle; held through RESP
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      rsp_rdata <= {DATA_W{1'b0}};
      rsp_err   <= 1'b0;
    end else if ((state_r == ST_ACCESS) && done_s) begin
      rsp_rdata <= (!pwrite && !err_s) ? prdata : {DATA_W{1'b0}};
      rsp_err   <= err_s;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge (directed steps plus response scoreboard).
// Wait-state and timeout steps are compiled in only with APB_MST_PREADY_EN.
module tb_apb_master_bridge;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        pclk = 1'b0;
  logic        prst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = 32'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic        cmd_write = 1'b0;
  logic [2:0]  cmd_prot = 3'b000;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic [2:0]  pprot;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata = 32'h0;

  int total = 0;
  int bad   = 0;
  rsp_t sb_q[$];

  always #5 pclk = ~pclk;

`ifdef APB_MST_PREADY_EN
  logic pready;
  logic pslverr = 1'b0;
  int   wait_n  = 0;
  int   acc_cnt = 0;

  // slave model: hold pready low for wait_n ACCESS cycles
  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
  end
  assign pready = (acc_cnt >= wait_n);
`endif

  apb_master_bridge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .pclk      (pclk),
    .prst      (prst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_write (cmd_write),
    .cmd_prot  (cmd_prot),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pprot     (pprot),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
`ifdef APB_MST_PREADY_EN
    .pready    (pready),
    .pslverr   (pslverr),
`endif
    .prdata    (prdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive a command, wait for acceptance, then check the SETUP cycle
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic [2:0] p, input logic [31:0] exp_rd, input logic exp_err);
    int n;
    rsp_t e;
    cmd_addr = a; cmd_wdata = d; cmd_write = w; cmd_prot = p; cmd_valid = 1'b1;
    e.rdata = exp_rd; e.err = exp_err;
    sb_q.push_back(e);
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge pclk);
      n++;
    end
    check("accept_bound", {31'd0, cmd_ready}, 32'd1);
    @(negedge pclk);
    cmd_valid = 1'b0;
    check("setup_psel", {31'd0, psel}, 32'd1);
    check("setup_penable", {31'd0, penable}, 32'd0);
    check("setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("setup_paddr", paddr, a);
  endtask

  // called on the SETUP negedge; waits for the response and scores it
  task automatic collect(output int lat, output int en);
    rsp_t e;
    lat = 1;
    en  = 0;
    while (!rsp_valid && lat < 60) begin
      if (penable) en++;
      @(negedge pclk);
      lat++;
    end
    check("rsp_bound", {31'd0, rsp_valid}, 32'd1);
    if (rsp_valid && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("rsp_rdata", rsp_rdata, e.rdata);
      check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      check("resp_psel", {31'd0, psel}, 32'd0);
      if (rsp_ready) begin
        @(negedge pclk);
        check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, en, n;
    rsp_t e;

    // reset values
    @(negedge pclk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_psel", {31'd0, psel}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_paddr", paddr, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    prst = 1'b0;
    @(negedge pclk);
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // zero-wait read
    prdata = 32'hDEAD_BEEF;
    issue(32'h4000_0010, 32'h0, 1'b0, 3'b000, 32'hDEAD_BEEF, 1'b0);
    collect(lat, en);
    check("read_latency", lat, 32'd3);
    check("read_penable_cycles", en, 32'd1);

    // write: response data is zero regardless of prdata
    prdata = 32'hA5A5_A5A5;
    issue(32'h4000_0020, 32'h1234_5678, 1'b1, 3'b010, 32'h0, 1'b0);
    collect(lat, en);
    check("write_latency", lat, 32'd3);
    check("write_pwrite", {31'd0, pwrite}, 32'd1);
    check("write_pwdata", pwdata, 32'h1234_5678);
    check("write_pprot", {29'd0, pprot}, 32'd2);
    check("write_paddr_hold", paddr, 32'h4000_0020);

    // response back-pressure with a second command waiting
    rsp_ready = 1'b0;
    prdata = 32'h0BAD_F00D;
    issue(32'h4000_0030, 32'h0, 1'b0, 3'b001, 32'h0BAD_F00D, 1'b0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge pclk);
      n++;
    end
    e = sb_q.pop_front();
    prdata = 32'h0;
    cmd_addr = 32'h4000_0040; cmd_wdata = 32'h55AA_55AA; cmd_write = 1'b1; cmd_prot = 3'b100;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rsp_rdata", rsp_rdata, e.rdata);
      check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("hold_psel", {31'd0, psel}, 32'd0);
      @(negedge pclk);
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    check("hold_release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("hold_release_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("hold_release_psel", {31'd0, psel}, 32'd0);
    e.rdata = 32'h0; e.err = 1'b0;
    sb_q.push_back(e);
    @(negedge pclk);
    cmd_valid = 1'b0;
    check("second_psel", {31'd0, psel}, 32'd1);
    check("second_paddr", paddr, 32'h4000_0040);
    collect(lat, en);
    check("second_pwdata", pwdata, 32'h55AA_55AA);

`ifdef APB_MST_PREADY_EN
    // three wait states then slave error
    wait_n = 3; pslverr = 1'b1; prdata = 32'h1111_2222;
    issue(32'h4000_0050, 32'h0, 1'b0, 3'b000, 32'h0, 1'b1);
    collect(lat, en);
    check("wait3_penable_cycles", en, 32'd4);
    // two wait states, clean read
    wait_n = 2; pslverr = 1'b0; prdata = 32'h3333_4444;
    issue(32'h4000_0060, 32'h0, 1'b0, 3'b000, 32'h3333_4444, 1'b0);
    collect(lat, en);
    check("wait2_penable_cycles", en, 32'd3);
    // pready stuck low: abort after TIMEOUT=4 ACCESS cycles
    wait_n = 1000; prdata = 32'h7777_8888;
    issue(32'h4000_0070, 32'h0, 1'b0, 3'b000, 32'h0, 1'b1);
    collect(lat, en);
    check("timeout_penable_cycles", en, 32'd4);
    wait_n = 0;
`endif

    // reset in the middle of ACCESS
    prdata = 32'hCAFE_F00D;
    issue(32'h4000_0080, 32'h0, 1'b0, 3'b000, 32'hCAFE_F00D, 1'b0);
    @(negedge pclk);
    check("mid_access_penable", {31'd0, penable}, 32'd1);
    prst = 1'b1;
    #1;
    check("async_rst_psel", {31'd0, psel}, 32'd0);
    check("async_rst_penable", {31'd0, penable}, 32'd0);
    sb_q.delete();
    @(negedge pclk);
    prst = 1'b0;
    @(negedge pclk);
    check("after_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("after_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("after_rst_psel", {31'd0, psel}, 32'd0);
      @(negedge pclk);
    end

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Single-outstanding APB initiator that converts a valid/ready command port into APB SETUP/ACCESS sequences and returns read data/status on a valid/ready response port. Sits between an on-chip requester (debug port, DMA descriptor loader, boot sequencer) and the APB peripheral fabric. It drives the same APB signal set that the peripheral-side dummy and real slaves consume.

## Interface
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 255, ACCESS-phase cycle limit; used only with APB_MST_PREADY_EN; legal 1..65535
- pclk  in  1  APB clock; all state on rising edge
- prst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  bridge accepts command this cycle
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- cmd_write  in  1  1 = write, 0 = read
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  response available
- rsp_ready  in  1  requester takes response
- rsp_rdata  out  DATA_W  read data; 0 for writes and for errors
- rsp_err  out  1  slave error or timeout
- paddr  out  ADDR_W  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pprot  out  3  APB protection
- pwrite  out  1  APB direction
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  slave ready; present only with APB_MST_PREADY_EN
- pslverr  in  1  slave error; present only with APB_MST_PREADY_EN

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. cmd_valid&cmd_ready latches addr/wdata/write/prot into paddr/pwdata/pwrite/pprot; next state SETUP.
- SETUP: psel=1, penable=0, cmd_ready=0; next state ACCESS unconditionally.
- ACCESS: psel=1, penable=1. Transfer completes on the completion condition (see Configuration). On completion: rsp_rdata=prdata for reads, 0 for writes; rsp_err captured; next state RESP.
- RESP: psel=0, penable=0, rsp_valid=1. Response and all rsp_* fields are held stable until rsp_ready=1; then IDLE. rsp_ready outside RESP is ignored.
- paddr/pwdata/pwrite/pprot hold the last command's values between transfers; they change only on command acceptance.
- Only one command is in flight. A new command is not accepted until the response handshake completes.
- Reset values: state IDLE; psel, penable, pwrite, rsp_valid, rsp_err = 0; paddr, pwdata, pprot, rsp_rdata = 0; cmd_ready = 0 while prst is high, 1 in IDLE after release.
- prst asserted mid-transfer: psel/penable drop immediately (asynchronously), the transfer and any pending response are discarded, and no response is issued after release.

## Timing
- Cycle 0: cmd handshake. Cycle 1: SETUP. Cycle 2: first ACCESS cycle. Cycle 3: rsp_valid (zero wait states).
- Minimum command-to-command spacing: 4 cycles, given rsp_ready=1 in the first RESP cycle.
- cmd_ready is a registered state decode with no combinational path from cmd_valid. rsp_valid is also a registered state decode.
- prdata is sampled only on the ACCESS cycle that completes the transfer.

## Configuration
- APB_MST_PREADY_EN defined:
  - pready/pslverr ports exist.
  - ACCESS completes when pready=1; rsp_err=pslverr on that cycle.
  - A 16-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - If pready is still 0 after TIMEOUT ACCESS cycles, the transfer is aborted: RESP is entered with rsp_err=1 and rsp_rdata=0.
- APB_MST_PREADY_EN undefined:
  - Ports are absent; no counter is present.
  - ACCESS always lasts exactly one cycle and rsp_err is always 0.

## Structure
- Package apb_mst_pkg holds the FSM state typedef (2-bit encoding), the default widths, and the counter width constant.
- One sub-module, apb_mst_wdog: the ACCESS-phase timeout counter with clear/count/expired signals. It is instantiated only under APB_MST_PREADY_EN.

## Test plan
- Read 0x4000_0010, slave returns 0xDEAD_BEEF with zero waits -> psel at cycle 1, penable at cycle 2, rsp_valid at cycle 3 with rsp_rdata=0xDEAD_BEEF, rsp_err=0.
- Write 0x4000_0020 data 0x1234_5678 prot 3'b010 -> pwrite=1, pwdata=0x1234_5678, pprot=2, rsp_rdata=0, rsp_err=0.
- Hold rsp_ready=0 for 5 cycles after a read -> rsp_* stable for the whole hold, cmd_ready=0 throughout, and a second cmd_valid is not accepted until the cycle after the rsp handshake.
- (macro) pready low for 3 ACCESS cycles then high with pslverr=1 -> penable high for 4 cycles, rsp_err=1; with TIMEOUT=4 and pready stuck low -> abort after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0.
- Assert prst during ACCESS -> psel/penable=0 in the same cycle; after release, rsp_valid stays 0 and cmd_ready=1.
